rom_port_arbiter: RTL and testbench
===================================

// Module: rom_port_arbiter
// PURPOSE
//  Shares the single genrom read port between the CPU instruction-fetch path (port F)
//  and the data/local-load path (port D). One transaction in flight; round-robin
//  on contention. Per-requester bounds are applied to the ROM port for the duration
//  of each grant. Read data and the ROM error flag return to the granted requester.
// PARAMETERS
//  MEM_ADDR    6  address MSB index; addresses are MEM_ADDR+1 bits wide
//  MEM_EXTRA   4  extra-byte select width; data is 2**MEM_EXTRA*8 bits
//  ROM_LATENCY 1  edges from mem_addr valid to mem_data valid (>=1)
// PORTS
//  clk              in   1               clock
//  reset            in   1               async, active-high
//  f_req/d_req      in   1               request; held high until ack
//  f_addr/d_addr    in   MEM_ADDR+1      byte address; stable while req high
//  f_extra/d_extra  in   MEM_EXTRA       extra bytes to read
//  f_lo/f_hi,d_lo/d_hi in MEM_ADDR+1     per-port lower/upper bounds
//  f_ack/d_ack      out  1               one-cycle completion pulse
//  f_data/d_data    out  2**MEM_EXTRA*8  read data, valid with ack, held until next ack
//  f_error/d_error  out  1               ROM error, valid with ack, held until next ack
//  mem_addr         out  MEM_ADDR+1      to genrom addr
//  mem_extra        out  MEM_EXTRA       to genrom extra
//  mem_lower_bound  out  MEM_ADDR+1      to genrom lower_bound
//  mem_upper_bound  out  MEM_ADDR+1      to genrom upper_bound
//  mem_data         in   2**MEM_EXTRA*8  from genrom data
//  mem_error        in   1               from genrom error
//  busy             out  1               high when state != IDLE
// BEHAVIOUR
//  Clock clk; reset is asynchronous and active-high.
//  Reset: state IDLE, acks 0, data/error 0, mem_addr/mem_extra 0, mem_lower_bound 0,
//   mem_upper_bound all ones, last_grant=D (so F wins first tie), busy 0.
//  FSM IDLE -> WAIT -> DONE -> IDLE.
//  IDLE: at edge with any req high: pick grantee, register mem_addr/extra and bounds
//   from grantee inputs, load cnt=ROM_LATENCY, go WAIT. No req: hold, mem_* unchanged.
//  Arbitration: single req -> grant it; both -> grant port != last_grant; update
//   last_grant on every grant.
//  WAIT: cnt decrements each edge; at edge with cnt==0 capture mem_data/mem_error
//   into grantee data/error, go DONE. mem_* held stable throughout WAIT.
//  DONE: grantee ack=1 for exactly this cycle; next edge -> IDLE. req ignored in
//   DONE; requester drops req by end of ack cycle or is re-served.
//  Latency: req-sampling edge t0 -> data captured at t0+ROM_LATENCY+1, ack high the
//   following cycle; back-to-back service interval ROM_LATENCY+3 cycles.
//  f_ack and d_ack never high together. Non-granted port's data/error unchanged.
//  Req dropped mid-transaction: transaction completes, ack still pulses.
//  Out-of-bounds: ack still issued; error carries mem_error, data passed as-is.
//  Reset mid-operation: immediate return to reset values; no ack for aborted read.
// TESTING
//  1 F only, f_addr=17, extra=0, ROM_LATENCY=1 -> f_ack 1 cycle, 3 edges after t0;
//    f_data=ROM[17]; d_ack stays 0; busy high 3 cycles.
//  2 F and D both held after reset -> grant order F,D,F,D over 4 acks; each ack 1 cycle.
//  3 D only, d_lo=32,d_hi=63,d_addr=10 -> mem_lower_bound=32,mem_upper_bound=63 in
//    WAIT; d_ack with d_error=1.
//  4 reset pulse during WAIT of F read -> busy/acks 0 immediately, no f_ack;
//    subsequent F req served with correct data.
//  5 ROM_LATENCY=3, D addr 20 extra=7 -> d_ack 5 edges after t0; d_data=8 bytes ROM[20..27].
//  6 F drops req during WAIT -> f_ack still pulses once; next pending D served next.

Source files
------------

// File: rtl/rom_port_arbiter_if.sv
// ============================================================================
// Module   : rom_port_arbiter_if
// Brief    : Requester (F/D) and genrom-side signal bundle for rom_port_arbiter
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rom_port_arbiter_if #(
    parameter int MEM_ADDR  = 6,
    parameter int MEM_EXTRA = 4
);
    localparam int c_DATA_W = (2 ** MEM_EXTRA) * 8;

    logic                  f_req;
    logic                  d_req;
    logic [MEM_ADDR:0]     f_addr;
    logic [MEM_ADDR:0]     d_addr;
    logic [MEM_EXTRA-1:0]  f_extra;
    logic [MEM_EXTRA-1:0]  d_extra;
    logic [MEM_ADDR:0]     f_lo;
    logic [MEM_ADDR:0]     f_hi;
    logic [MEM_ADDR:0]     d_lo;
    logic [MEM_ADDR:0]     d_hi;
    logic                  f_ack;
    logic                  d_ack;
    logic [c_DATA_W-1:0]   f_data;
    logic [c_DATA_W-1:0]   d_data;
    logic                  f_error;
    logic                  d_error;
    logic [MEM_ADDR:0]     mem_addr;
    logic [MEM_EXTRA-1:0]  mem_extra;
    logic [MEM_ADDR:0]     mem_lower_bound;
    logic [MEM_ADDR:0]     mem_upper_bound;
    logic [c_DATA_W-1:0]   mem_data;
    logic                  mem_error;
    logic                  busy;

    modport slave (
        input  f_req, d_req, f_addr, d_addr, f_extra, d_extra,
               f_lo, f_hi, d_lo, d_hi, mem_data, mem_error,
        output f_ack, d_ack, f_data, d_data, f_error, d_error,
               mem_addr, mem_extra, mem_lower_bound, mem_upper_bound, busy
    );

    modport master (
        output f_req, d_req, f_addr, d_addr, f_extra, d_extra,
               f_lo, f_hi, d_lo, d_hi, mem_data, mem_error,
        input  f_ack, d_ack, f_data, d_data, f_error, d_error,
               mem_addr, mem_extra, mem_lower_bound, mem_upper_bound, busy
    );
endinterface

`default_nettype wire

// File: rtl/rom_port_arbiter.sv
// ============================================================================
// Module   : rom_port_arbiter
// Brief    : Round-robin sharing of the genrom read port between fetch (F) and
//            data (D) requesters, one transaction in flight.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_port_arbiter #(
    parameter int MEM_ADDR    = 6,
    parameter int MEM_EXTRA   = 4,
    parameter int ROM_LATENCY = 1
) (
    input  wire logic             clk,
    input  wire logic             reset,
    rom_port_arbiter_if.slave     bus
);
    localparam int c_DATA_W = (2 ** MEM_EXTRA) * 8;
    localparam int c_CNT_W  = (ROM_LATENCY < 2) ? 1 : $clog2(ROM_LATENCY + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_LOAD = c_CNT_W'(ROM_LATENCY);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    localparam logic [1:0] c_IDLE = 2'd0;
    localparam logic [1:0] c_WAIT = 2'd1;
    localparam logic [1:0] c_DONE = 2'd2;

    localparam logic c_GRANT_F = 1'b0;
    localparam logic c_GRANT_D = 1'b1;

    logic [1:0]           state_q,     state_d;
    logic                 grant_q,     grant_d;
    logic [c_CNT_W-1:0]   cnt_q,       cnt_d;
    logic [MEM_ADDR:0]    mem_addr_q,  mem_addr_d;
    logic [MEM_EXTRA-1:0] mem_extra_q, mem_extra_d;
    logic [MEM_ADDR:0]    mem_lo_q,    mem_lo_d;
    logic [MEM_ADDR:0]    mem_hi_q,    mem_hi_d;
    logic                 f_ack_q,     f_ack_d;
    logic                 d_ack_q,     d_ack_d;
    logic [c_DATA_W-1:0]  f_data_q,    f_data_d;
    logic [c_DATA_W-1:0]  d_data_q,    d_data_d;
    logic                 f_error_q,   f_error_d;
    logic                 d_error_q,   d_error_d;

    logic                 w_pick_d;

    // grant_q doubles as last_grant: it always names the most recent grantee.
    assign w_pick_d = bus.d_req && (!bus.f_req || (grant_q == c_GRANT_F));

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_extra_d = mem_extra_q;
        mem_lo_d    = mem_lo_q;
        mem_hi_d    = mem_hi_q;
        f_ack_d     = 1'b0;
        d_ack_d     = 1'b0;
        f_data_d    = f_data_q;
        d_data_d    = d_data_q;
        f_error_d   = f_error_q;
        d_error_d   = d_error_q;

        case (state_q)
            c_IDLE: begin
                if (bus.f_req || bus.d_req) begin
                    cnt_d   = c_CNT_LOAD;
                    state_d = c_WAIT;
                    if (w_pick_d) begin
                        grant_d     = c_GRANT_D;
                        mem_addr_d  = bus.d_addr;
                        mem_extra_d = bus.d_extra;
                        mem_lo_d    = bus.d_lo;
                        mem_hi_d    = bus.d_hi;
                    end else begin
                        grant_d     = c_GRANT_F;
                        mem_addr_d  = bus.f_addr;
                        mem_extra_d = bus.f_extra;
                        mem_lo_d    = bus.f_lo;
                        mem_hi_d    = bus.f_hi;
                    end
                end
            end
            c_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = c_DONE;
                    if (grant_q == c_GRANT_D) begin
                        d_data_d  = bus.mem_data;
                        d_error_d = bus.mem_error;
                        d_ack_d   = 1'b1;
                    end else begin
                        f_data_d  = bus.mem_data;
                        f_error_d = bus.mem_error;
                        f_ack_d   = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q - c_CNT_ONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= c_IDLE;
            grant_q     <= c_GRANT_D;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_extra_q <= '0;
            mem_lo_q    <= '0;
            mem_hi_q    <= '1;
            f_ack_q     <= 1'b0;
            d_ack_q     <= 1'b0;
            f_data_q    <= '0;
            d_data_q    <= '0;
            f_error_q   <= 1'b0;
            d_error_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_extra_q <= mem_extra_d;
            mem_lo_q    <= mem_lo_d;
            mem_hi_q    <= mem_hi_d;
            f_ack_q     <= f_ack_d;
            d_ack_q     <= d_ack_d;
            f_data_q    <= f_data_d;
            d_data_q    <= d_data_d;
            f_error_q   <= f_error_d;
            d_error_q   <= d_error_d;
        end
    end

    assign bus.mem_addr        = mem_addr_q;
    assign bus.mem_extra       = mem_extra_q;
    assign bus.mem_lower_bound = mem_lo_q;
    assign bus.mem_upper_bound = mem_hi_q;
    assign bus.f_ack           = f_ack_q;
    assign bus.d_ack           = d_ack_q;
    assign bus.f_data          = f_data_q;
    assign bus.d_data          = d_data_q;
    assign bus.f_error         = f_error_q;
    assign bus.d_error         = d_error_q;
    assign bus.busy            = (state_q != c_IDLE);

endmodule

`default_nettype wire

// File: tb/tb_rom_port_arbiter.sv
// ============================================================================
// Module   : tb_rom_port_arbiter
// Brief    : Directed self-checking bench; two arbiters (latency 1 and 3),
//            each fed by a behavioural genrom with matching pipeline depth.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_rom_port_arbiter;
    logic clk;
    logic rst;

    int n_checks = 0;
    int n_fail   = 0;
    int n_both   = 0;
    int busy_cnt;
    int ack_cyc[$];
    bit ack_port[$];

    rom_port_arbiter_if #(.MEM_ADDR(6), .MEM_EXTRA(4)) ifa ();
    rom_port_arbiter_if #(.MEM_ADDR(6), .MEM_EXTRA(4)) ifb ();

    rom_port_arbiter #(.MEM_ADDR(6), .MEM_EXTRA(4), .ROM_LATENCY(1)) u_dut_a (
        .clk   (clk),
        .reset (rst),
        .bus   (ifa)
    );

    rom_port_arbiter #(.MEM_ADDR(6), .MEM_EXTRA(4), .ROM_LATENCY(3)) u_dut_b (
        .clk   (clk),
        .reset (rst),
        .bus   (ifb)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [7:0] rom_byte(input logic [6:0] a);
        return 8'((int'(a) * 5 + 11) & 255);
    endfunction

    function automatic logic [127:0] rom_read(input logic [6:0] a, input logic [3:0] x);
        logic [127:0] r;
        r = '0;
        for (int i = 0; i < 16; i++)
            if (i <= int'(x)) r[8*i +: 8] = rom_byte(7'((int'(a) + i) & 127));
        return r;
    endfunction

    function automatic logic rom_err(input logic [6:0] a, input logic [3:0] x,
                                     input logic [6:0] lo, input logic [6:0] hi);
        return (a < lo) || ((int'(a) + int'(x)) > int'(hi));
    endfunction

    // genrom models: data valid ROM_LATENCY edges after mem_addr
    logic [127:0] pa_d;
    logic         pa_e;
    logic [127:0] pb_d[3];
    logic         pb_e[3];

    always @(posedge clk) begin
        pa_d    <= rom_read(ifa.mem_addr, ifa.mem_extra);
        pa_e    <= rom_err(ifa.mem_addr, ifa.mem_extra, ifa.mem_lower_bound, ifa.mem_upper_bound);
        pb_d[0] <= rom_read(ifb.mem_addr, ifb.mem_extra);
        pb_e[0] <= rom_err(ifb.mem_addr, ifb.mem_extra, ifb.mem_lower_bound, ifb.mem_upper_bound);
        pb_d[1] <= pb_d[0];
        pb_e[1] <= pb_e[0];
        pb_d[2] <= pb_d[1];
        pb_e[2] <= pb_e[1];
    end

    assign ifa.mem_data  = pa_d;
    assign ifa.mem_error = pa_e;
    assign ifb.mem_data  = pb_d[2];
    assign ifb.mem_error = pb_e[2];

    task automatic check_value(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic int qcyc(input int i);
        return (i < ack_cyc.size()) ? ack_cyc[i] : -1;
    endfunction

    function automatic int qport(input int i);
        return (i < ack_port.size()) ? int'(ack_port[i]) : -1;
    endfunction

    // Walks negedges k0..k1 after the grant edge, logging acks on instance A.
    task automatic observe_a(input int k0, input int k1, input bit auto_drop);
        ack_cyc.delete();
        ack_port.delete();
        busy_cnt = 0;
        for (int k = k0; k <= k1; k++) begin
            @(negedge clk);
            if (ifa.busy) busy_cnt++;
            if (ifa.f_ack && ifa.d_ack) n_both++;
            if (ifa.f_ack) begin
                ack_cyc.push_back(k);
                ack_port.push_back(1'b0);
                if (auto_drop) ifa.f_req = 1'b0;
            end
            if (ifa.d_ack) begin
                ack_cyc.push_back(k);
                ack_port.push_back(1'b1);
                if (auto_drop) ifa.d_req = 1'b0;
            end
        end
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin : stim
        int first_d;
        int n_dack;
        int n_fack;

        rst = 1'b1;
        ifa.f_req = 0; ifa.d_req = 0; ifa.f_addr = 0; ifa.d_addr = 0;
        ifa.f_extra = 0; ifa.d_extra = 0;
        ifa.f_lo = 0; ifa.f_hi = 7'h7f; ifa.d_lo = 0; ifa.d_hi = 7'h7f;
        ifb.f_req = 0; ifb.d_req = 0; ifb.f_addr = 0; ifb.d_addr = 0;
        ifb.f_extra = 0; ifb.d_extra = 0;
        ifb.f_lo = 0; ifb.f_hi = 7'h7f; ifb.d_lo = 0; ifb.d_hi = 7'h7f;
        repeat (3) @(negedge clk);

        check_value("rst_busy",  ifa.busy, 0);
        check_value("rst_fack",  ifa.f_ack, 0);
        check_value("rst_dack",  ifa.d_ack, 0);
        check_value("rst_maddr", ifa.mem_addr, 0);
        check_value("rst_mlo",   ifa.mem_lower_bound, 0);
        check_value("rst_mhi",   ifa.mem_upper_bound, 7'h7f);
        check_value("rst_fdata", ifa.f_data, 0);
        check_value("rst_b_busy", ifb.busy, 0);
        rst = 1'b0;
        @(negedge clk);

        // F-only single read
        ifa.f_req = 1; ifa.f_addr = 7'd17; ifa.f_extra = 0;
        observe_a(1, 6, 1);
        check_value("t1_nack",  ack_cyc.size(), 1);
        check_value("t1_cyc",   qcyc(0), 3);
        check_value("t1_port",  qport(0), 0);
        check_value("t1_busy",  busy_cnt, 3);
        check_value("t1_fdata", ifa.f_data, rom_read(7'd17, 4'd0));
        check_value("t1_ferr",  ifa.f_error, 0);

        // both held after reset: F,D,F,D every 4 cycles
        pulse_reset();
        ifa.f_req = 1; ifa.f_addr = 7'd5;
        ifa.d_req = 1; ifa.d_addr = 7'd40;
        observe_a(1, 16, 0);
        ifa.f_req = 0; ifa.d_req = 0;
        check_value("t2_nack", ack_cyc.size(), 4);
        check_value("t2_p0", qport(0), 0);
        check_value("t2_p1", qport(1), 1);
        check_value("t2_p2", qport(2), 0);
        check_value("t2_p3", qport(3), 1);
        check_value("t2_c1", qcyc(1), 7);
        check_value("t2_c3", qcyc(3), 15);
        check_value("t2_fdata", ifa.f_data, rom_read(7'd5, 4'd0));
        check_value("t2_ddata", ifa.d_data, rom_read(7'd40, 4'd0));
        @(negedge clk);

        // D-only, out of its own bounds
        ifa.d_req = 1; ifa.d_addr = 7'd10; ifa.d_extra = 0;
        ifa.d_lo = 7'd32; ifa.d_hi = 7'd63;
        @(negedge clk);
        check_value("t3_mlo",   ifa.mem_lower_bound, 7'd32);
        check_value("t3_mhi",   ifa.mem_upper_bound, 7'd63);
        check_value("t3_maddr", ifa.mem_addr, 7'd10);
        observe_a(2, 6, 1);
        check_value("t3_cyc",   qcyc(0), 3);
        check_value("t3_port",  qport(0), 1);
        check_value("t3_derr",  ifa.d_error, 1);
        check_value("t3_ddata", ifa.d_data, rom_read(7'd10, 4'd0));
        check_value("t3_fkeep", ifa.f_data, rom_read(7'd5, 4'd0));
        ifa.d_lo = 0; ifa.d_hi = 7'h7f;

        // reset during WAIT aborts the read
        ifa.f_req = 1; ifa.f_addr = 7'd50;
        @(negedge clk);
        rst = 1'b1; ifa.f_req = 0;
        #1;
        check_value("t4_busy",  ifa.busy, 0);
        check_value("t4_fack",  ifa.f_ack, 0);
        check_value("t4_fdata", ifa.f_data, 0);
        check_value("t4_mhi",   ifa.mem_upper_bound, 7'h7f);
        @(negedge clk);
        rst = 1'b0;
        observe_a(1, 4, 1);
        check_value("t4_noack", ack_cyc.size(), 0);
        ifa.f_req = 1; ifa.f_addr = 7'd51;
        observe_a(1, 6, 1);
        check_value("t4_cyc",   qcyc(0), 3);
        check_value("t4_fdata2", ifa.f_data, rom_read(7'd51, 4'd0));

        // F drops req during WAIT while D becomes pending
        ifa.f_req = 1; ifa.f_addr = 7'd60;
        @(negedge clk);
        ifa.f_req = 0; ifa.d_req = 1; ifa.d_addr = 7'd70;
        observe_a(2, 10, 1);
        check_value("t6_nack",  ack_cyc.size(), 2);
        check_value("t6_c0",    qcyc(0), 3);
        check_value("t6_p0",    qport(0), 0);
        check_value("t6_c1",    qcyc(1), 7);
        check_value("t6_p1",    qport(1), 1);
        check_value("t6_fdata", ifa.f_data, rom_read(7'd60, 4'd0));
        check_value("t6_ddata", ifa.d_data, rom_read(7'd70, 4'd0));
        check_value("ack_excl", n_both, 0);

        // latency-3 instance, 8-byte read
        first_d = -1; n_dack = 0; n_fack = 0;
        ifb.d_req = 1; ifb.d_addr = 7'd20; ifb.d_extra = 4'd7;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (ifb.f_ack) n_fack++;
            if (ifb.d_ack) begin
                n_dack++;
                if (first_d < 0) first_d = k;
                ifb.d_req = 0;
            end
        end
        check_value("t5_cyc",   first_d, 5);
        check_value("t5_ndack", n_dack, 1);
        check_value("t5_nfack", n_fack, 0);
        check_value("t5_ddata", ifb.d_data, rom_read(7'd20, 4'd7));
        check_value("t5_derr",  ifb.d_error, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

`default_nettype wire
